// File: rtl/cfg_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : cfg_regfile_if
// Brief    : Wishbone classic slave bus bundle for cfg_regfile.
// Revision : 1.0 - initial release
// ============================================================================
interface cfg_regfile_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cfg_regfile
// Brief    : Wishbone register block issuing word-serial conv1/conv2/fc
//            parameter-memory commands. Optional macro CFG_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_regfile #(
    parameter int          CONV1_BANK_BW      = 3,
    parameter int          CONV1_ADDR_BW      = 3,
    parameter int          CONV1_VECTOR_BW    = 104,
    parameter int          CONV2_BANK_BW      = 3,
    parameter int          CONV2_ADDR_BW      = 4,
    parameter int          CONV2_VECTOR_BW    = 64,
    parameter int          FC_BANK_BW         = 2,
    parameter int          FC_ADDR_BW         = 8,
    parameter int          FC_BIAS_BW         = 32,
    parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    cfg_regfile_if.slave               wb,
    output logic                       conv1_rd_en_o,
    output logic                       conv1_wr_en_o,
    output logic [CONV1_BANK_BW-1:0]   conv1_rd_wr_bank_o,
    output logic [CONV1_ADDR_BW-1:0]   conv1_rd_wr_addr_o,
    output logic [CONV1_VECTOR_BW-1:0] conv1_wr_data_o,
    input  logic [CONV1_VECTOR_BW-1:0] conv1_rd_data_i,
    output logic                       conv2_rd_en_o,
    output logic                       conv2_wr_en_o,
    output logic [CONV2_BANK_BW-1:0]   conv2_rd_wr_bank_o,
    output logic [CONV2_ADDR_BW-1:0]   conv2_rd_wr_addr_o,
    output logic [CONV2_VECTOR_BW-1:0] conv2_wr_data_o,
    input  logic [CONV2_VECTOR_BW-1:0] conv2_rd_data_i,
    output logic                       fc_rd_en_o,
    output logic                       fc_wr_en_o,
    output logic [FC_BANK_BW-1:0]      fc_rd_wr_bank_o,
    output logic [FC_ADDR_BW-1:0]      fc_rd_wr_addr_o,
    output logic [FC_BIAS_BW-1:0]      fc_wr_data_o,
    input  logic [FC_BIAS_BW-1:0]      fc_rd_data_i
);
    localparam int         c_VEC_BW     = 104;
    localparam logic [5:0] c_OFS_CMD    = 6'h00;
    localparam logic [5:0] c_OFS_STATUS = 6'h01;
    localparam logic [5:0] c_OFS_WD0    = 6'h04;
    localparam logic [5:0] c_OFS_WD3    = 6'h07;
    localparam logic [5:0] c_OFS_RD0    = 6'h08;
    localparam logic [1:0] c_TGT_CONV1  = 2'd0;
    localparam logic [1:0] c_TGT_CONV2  = 2'd1;
    localparam logic [1:0] c_TGT_NONE   = 2'd3;
`ifdef CFG_READBACK_EN
    localparam logic       c_READBACK   = 1'b1;
`else
    localparam logic       c_READBACK   = 1'b0;
`endif

    logic                     w_hit, w_req, w_cmd_wr, w_go_wr, w_go_rd, w_unused_bits;
    logic [5:0]               w_ofs;
    logic [1:0]               w_tgt;
    logic [31:0]              w_rd_mux;
    logic                     r_ack_q, r_done_q, r_pend_q;
    logic [31:0]              r_dat_q, r_cmd_q;
    logic [c_VEC_BW-1:0]      r_wdata_q, r_rdata_q;
    logic [2:0]               r_wr_en_q, r_rd_en_q;
    logic [CONV1_BANK_BW-1:0] r_c1_bank_q;
    logic [CONV1_ADDR_BW-1:0] r_c1_addr_q;
    logic [CONV2_BANK_BW-1:0] r_c2_bank_q;
    logic [CONV2_ADDR_BW-1:0] r_c2_addr_q;
    logic [FC_BANK_BW-1:0]    r_fc_bank_q;
    logic [FC_ADDR_BW-1:0]    r_fc_addr_q;

    // A pending read capture holds off the next access so RDATA/STATUS are never stale.
    assign w_hit    = (wb.wbs_adr_i[31:8] == WISHBONE_BASE_ADDR[31:8]);
    assign w_req    = wb.wbs_stb_i & wb.wbs_cyc_i & w_hit & ~r_ack_q & ~r_pend_q;
    assign w_ofs    = wb.wbs_adr_i[7:2];
    assign w_tgt    = wb.wbs_dat_i[1:0];
    assign w_cmd_wr = w_req & wb.wbs_we_i & (w_ofs == c_OFS_CMD) & (wb.wbs_sel_i == 4'hF);
    assign w_go_wr  = w_cmd_wr &  wb.wbs_dat_i[2] & (w_tgt != c_TGT_NONE);
    assign w_go_rd  = w_cmd_wr & ~wb.wbs_dat_i[2] & (w_tgt != c_TGT_NONE) & c_READBACK;

    always_comb begin
        w_rd_mux = '0;
        case (w_ofs)
            c_OFS_CMD:     w_rd_mux = r_cmd_q;
            c_OFS_STATUS:  w_rd_mux = {31'd0, r_done_q};
            c_OFS_WD0:     w_rd_mux = r_wdata_q[31:0];
            6'h05:         w_rd_mux = r_wdata_q[63:32];
            6'h06:         w_rd_mux = r_wdata_q[95:64];
            c_OFS_WD3:     w_rd_mux = {24'd0, r_wdata_q[103:96]};
            c_OFS_RD0:     w_rd_mux = r_rdata_q[31:0];
            6'h09:         w_rd_mux = r_rdata_q[63:32];
            6'h0A:         w_rd_mux = r_rdata_q[95:64];
            6'h0B:         w_rd_mux = {24'd0, r_rdata_q[103:96]};
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack_q     <= 1'b0;
            r_dat_q     <= '0;
            r_cmd_q     <= '0;
            r_wdata_q   <= '0;
            r_wr_en_q   <= '0;
            r_c1_bank_q <= '0;
            r_c1_addr_q <= '0;
            r_c2_bank_q <= '0;
            r_c2_addr_q <= '0;
            r_fc_bank_q <= '0;
            r_fc_addr_q <= '0;
        end else begin
            r_ack_q   <= w_req;
            r_dat_q   <= (w_req && !wb.wbs_we_i) ? w_rd_mux : '0;
            r_wr_en_q <= '0;
            if (w_go_wr)
                r_wr_en_q <= 3'b001 << w_tgt;
            if (w_cmd_wr)
                r_cmd_q <= wb.wbs_dat_i;
            if (w_go_wr || w_go_rd) begin
                case (w_tgt)
                    c_TGT_CONV1: begin
                        r_c1_bank_q <= wb.wbs_dat_i[8 +: CONV1_BANK_BW];
                        r_c1_addr_q <= wb.wbs_dat_i[16 +: CONV1_ADDR_BW];
                    end
                    c_TGT_CONV2: begin
                        r_c2_bank_q <= wb.wbs_dat_i[8 +: CONV2_BANK_BW];
                        r_c2_addr_q <= wb.wbs_dat_i[16 +: CONV2_ADDR_BW];
                    end
                    default: begin
                        r_fc_bank_q <= wb.wbs_dat_i[8 +: FC_BANK_BW];
                        r_fc_addr_q <= wb.wbs_dat_i[16 +: FC_ADDR_BW];
                    end
                endcase
            end
            if (w_req && wb.wbs_we_i) begin
                for (int i = 0; i < 3; i++) begin
                    if (w_ofs == c_OFS_WD0 + 6'(i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wb.wbs_sel_i[b])
                                r_wdata_q[i*32 + b*8 +: 8] <= wb.wbs_dat_i[b*8 +: 8];
                        end
                    end
                end
                // Only the low byte of WDATA3 backs real vector bits.
                if (w_ofs == c_OFS_WD3 && wb.wbs_sel_i[0])
                    r_wdata_q[96 +: 8] <= wb.wbs_dat_i[7:0];
            end
        end
    end

`ifdef CFG_READBACK_EN
    logic [1:0] r_pend_tgt_q;

    // Memory returns data the cycle after rd_en; r_pend_q marks that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_en_q    <= '0;
            r_pend_q     <= 1'b0;
            r_pend_tgt_q <= '0;
            r_rdata_q    <= '0;
            r_done_q     <= 1'b0;
        end else begin
            r_rd_en_q <= '0;
            if (w_go_rd) begin
                r_rd_en_q    <= 3'b001 << w_tgt;
                r_pend_tgt_q <= w_tgt;
            end
            r_pend_q <= |r_rd_en_q;
            if (r_pend_q) begin
                r_done_q <= 1'b1;
                case (r_pend_tgt_q)
                    c_TGT_CONV1: r_rdata_q <= c_VEC_BW'(conv1_rd_data_i);
                    c_TGT_CONV2: r_rdata_q <= c_VEC_BW'(conv2_rd_data_i);
                    default:     r_rdata_q <= c_VEC_BW'(fc_rd_data_i);
                endcase
            end else if (w_cmd_wr) begin
                r_done_q <= 1'b0;
            end
        end
    end

    assign w_unused_bits = ^wb.wbs_adr_i[1:0];
`else
    assign r_rd_en_q     = '0;
    assign r_pend_q      = 1'b0;
    assign r_rdata_q     = '0;
    assign r_done_q      = 1'b0;
    assign w_unused_bits = ^{wb.wbs_adr_i[1:0], conv1_rd_data_i, conv2_rd_data_i, fc_rd_data_i};
`endif

    assign wb.wbs_ack_o         = r_ack_q;
    assign wb.wbs_dat_o         = r_dat_q;
    assign conv1_wr_en_o        = r_wr_en_q[0];
    assign conv2_wr_en_o        = r_wr_en_q[1];
    assign fc_wr_en_o           = r_wr_en_q[2];
    assign conv1_rd_en_o        = r_rd_en_q[0];
    assign conv2_rd_en_o        = r_rd_en_q[1];
    assign fc_rd_en_o           = r_rd_en_q[2];
    assign conv1_rd_wr_bank_o   = r_c1_bank_q;
    assign conv1_rd_wr_addr_o   = r_c1_addr_q;
    assign conv2_rd_wr_bank_o   = r_c2_bank_q;
    assign conv2_rd_wr_addr_o   = r_c2_addr_q;
    assign fc_rd_wr_bank_o      = r_fc_bank_q;
    assign fc_rd_wr_addr_o      = r_fc_addr_q;
    assign conv1_wr_data_o      = r_wdata_q[CONV1_VECTOR_BW-1:0];
    assign conv2_wr_data_o      = r_wdata_q[CONV2_VECTOR_BW-1:0];
    assign fc_wr_data_o         = r_wdata_q[FC_BIAS_BW-1:0];
endmodule
`default_nettype wire

// File: tb/tb_cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_regfile
// Brief    : Directed + randomized bench for cfg_regfile with a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_regfile;
`ifdef CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cfg_regfile_if bus();

    logic         c1_rd_en, c1_wr_en, c2_rd_en, c2_wr_en, fc_rd_en, fc_wr_en;
    logic [2:0]   c1_bank, c1_addr, c2_bank;
    logic [3:0]   c2_addr;
    logic [1:0]   fc_bank;
    logic [7:0]   fc_addr;
    logic [103:0] c1_wd, c1_rd_data;
    logic [63:0]  c2_wd, c2_rd_data;
    logic [31:0]  fc_wd, fc_rd_data;
    logic [5:0]   w_strobes;

    assign w_strobes = {fc_rd_en, c2_rd_en, c1_rd_en, fc_wr_en, c2_wr_en, c1_wr_en};

    cfg_regfile dut (
        .clk_i(clk), .rst_i(rst), .wb(bus),
        .conv1_rd_en_o(c1_rd_en), .conv1_wr_en_o(c1_wr_en),
        .conv1_rd_wr_bank_o(c1_bank), .conv1_rd_wr_addr_o(c1_addr),
        .conv1_wr_data_o(c1_wd), .conv1_rd_data_i(c1_rd_data),
        .conv2_rd_en_o(c2_rd_en), .conv2_wr_en_o(c2_wr_en),
        .conv2_rd_wr_bank_o(c2_bank), .conv2_rd_wr_addr_o(c2_addr),
        .conv2_wr_data_o(c2_wd), .conv2_rd_data_i(c2_rd_data),
        .fc_rd_en_o(fc_rd_en), .fc_wr_en_o(fc_wr_en),
        .fc_rd_wr_bank_o(fc_bank), .fc_rd_wr_addr_o(fc_addr),
        .fc_wr_data_o(fc_wd), .fc_rd_data_i(fc_rd_data)
    );

    int n_pass = 0, n_total = 0, n_fail = 0, n_multi = 0;

    // Reference model kept as 32-bit register words.
    logic [31:0] m_wd[4];
    logic [31:0] m_rd[4];
    logic [31:0] m_cmd;
    logic        m_done;
    logic [7:0]  m_bank[3];
    logic [7:0]  m_addr[3];
    int          bank_mask[3] = '{7, 7, 3};
    int          addr_mask[3] = '{7, 15, 255};

    always @(negedge clk) if ($countones(w_strobes) > 1) n_multi++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin m_wd[i] = '0; m_rd[i] = '0; end
        for (int i = 0; i < 3; i++) begin m_bank[i] = '0; m_addr[i] = '0; end
        m_cmd = '0; m_done = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [5:0] w);
        if (w == 6'd0) return m_cmd;
        if (w == 6'd1) return RB ? {31'd0, m_done} : 32'd0;
        if (w >= 6'd4 && w <= 6'd7) return m_wd[w - 6'd4];
        if (w >= 6'd8 && w <= 6'd11) return RB ? m_rd[w - 6'd8] : 32'd0;
        return 32'd0;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "/bankaddr"}, {c1_bank, c1_addr, c2_bank, c2_addr, fc_bank, fc_addr},
            {m_bank[0][2:0], m_addr[0][2:0], m_bank[1][2:0], m_addr[1][3:0], m_bank[2][1:0], m_addr[2]});
        chk({tag, "/c1wd"}, c1_wd, {m_wd[3][7:0], m_wd[2], m_wd[1], m_wd[0]});
        chk({tag, "/c2fcwd"}, {c2_wd, fc_wd}, {m_wd[1], m_wd[0], m_wd[0]});
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, output logic acked, output logic [3:0] lat,
                           output logic [31:0] rdat, output logic [5:0] stb);
        bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel; bus.wbs_we_i = we;
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
        acked = 1'b0; lat = '0; rdat = '0; stb = '0;
        while (!acked && lat < 4'd4) begin
            @(posedge clk); #1;
            lat = lat + 4'd1;
            if (bus.wbs_ack_o) begin acked = 1'b1; rdat = bus.wbs_dat_o; stb = w_strobes; end
        end
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(posedge clk); #1;
        chk("ack_pulse", {bus.wbs_ack_o, bus.wbs_dat_o, w_strobes}, '0);
        @(posedge clk); #1;
    endtask

    task automatic step(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we);
        logic        hit, acked;
        logic [5:0]  w, exp_stb, stb;
        logic [3:0]  lat;
        logic [31:0] rdat, exp_dat, word, bmask;
        int          t, idx;
        hit = (adr[31:8] == 24'h30_0000);
        w = adr[7:2];
        t = int'(dat[1:0]);
        exp_dat = we ? 32'd0 : exp_read(w);
        exp_stb = '0;
        if (hit && we && w == 6'd0 && sel == 4'hF && t != 3) begin
            if (dat[2]) exp_stb = 6'(1 << t);
            else if (RB) exp_stb = 6'(8 << t);
        end
        wb_xfer(adr, dat, sel, we, acked, lat, rdat, stb);
        chk({tag, "/ack"}, {acked, (hit ? lat : 4'd0)}, {hit, (hit ? 4'd1 : 4'd0)});
        if (hit) begin
            chk({tag, "/strobe"}, stb, exp_stb);
            if (!we) chk({tag, "/rdata"}, rdat, exp_dat);
        end
        if (hit && we) begin
            if (w >= 6'd4 && w <= 6'd7) begin
                idx = int'(w) - 4;
                word = m_wd[idx];
                for (int b = 0; b < 4; b++) begin
                    bmask = 32'hFF << (8 * b);
                    if (sel[b]) word = (word & ~bmask) | (dat & bmask);
                end
                m_wd[idx] = word;
                m_wd[3] = m_wd[3] & 32'hFF;
            end
            if (w == 6'd0 && sel == 4'hF) begin
                m_cmd = dat;
                m_done = 1'b0;
                if (t != 3 && (dat[2] || RB)) begin
                    m_bank[t] = dat[15:8] & 8'(bank_mask[t]);
                    m_addr[t] = dat[23:16] & 8'(addr_mask[t]);
                end
                if (t != 3 && !dat[2] && RB) begin
                    m_done = 1'b1;
                    for (int i = 0; i < 4; i++) m_rd[i] = '0;
                    if (t == 0) begin
                        m_rd[0] = c1_rd_data[31:0];  m_rd[1] = c1_rd_data[63:32];
                        m_rd[2] = c1_rd_data[95:64]; m_rd[3] = {24'd0, c1_rd_data[103:96]};
                    end else if (t == 1) begin
                        m_rd[0] = c2_rd_data[31:0];  m_rd[1] = c2_rd_data[63:32];
                    end else begin
                        m_rd[0] = fc_rd_data;
                    end
                end
            end
        end
        check_outputs(tag);
    endtask

    initial begin
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = '0; bus.wbs_dat_i = '0; bus.wbs_adr_i = '0;
        c1_rd_data = '0; c2_rd_data = '0; fc_rd_data = '0;
        m_reset();
        rst = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        chk("reset/bus", {bus.wbs_ack_o, bus.wbs_dat_o, w_strobes}, '0);
        check_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        step("wd0_beef", 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        step("wd0_rd",   32'h3000_0010, 32'h0,         4'hF, 1'b0);

        step("wd0", 32'h3000_0010, 32'h1111_1111, 4'hF, 1'b1);
        step("wd1", 32'h3000_0014, 32'h2222_2222, 4'hF, 1'b1);
        step("wd2", 32'h3000_0018, 32'h3333_3333, 4'hF, 1'b1);
        step("wd3", 32'h3000_001C, 32'h0000_0044, 4'hF, 1'b1);
        step("c1wr", 32'h3000_0000, 32'h0003_0504, 4'hF, 1'b1);
        chk("c1wr/fixed", {c1_bank, c1_addr, c1_wd}, {3'd5, 3'd3, 104'h44_33333333_22222222_11111111});

        fc_rd_data = 32'hCAFE_0001;
        step("fcrd", 32'h3000_0000, 32'h00AB_0202, 4'hF, 1'b1);
        chk("fcrd/fixed", {fc_bank, fc_addr}, RB ? {2'd2, 8'hAB} : 10'd0);
        step("fcrd_rdata0", 32'h3000_0020, 32'h0, 4'hF, 1'b0);
        step("fcrd_status", 32'h3000_0004, 32'h0, 4'hF, 1'b0);
        step("tgt3", 32'h3000_0000, 32'h0000_0007, 4'hF, 1'b1);
        step("status_clr", 32'h3000_0004, 32'h0, 4'hF, 1'b0);
        step("sel1_cmd", 32'h3000_0000, 32'h0001_0105, 4'h1, 1'b1);
        step("cmd_rd", 32'h3000_0000, 32'h0, 4'hF, 1'b0);
        step("miss", 32'h3000_0100, 32'h0000_0004, 4'hF, 1'b1);
        step("sel_b1", 32'h3000_0014, 32'hAABB_CCDD, 4'b0010, 1'b1);
        chk("sel_b1/fixed", c2_wd[63:32], 32'h2222_CC22);

        for (int k = 0; k < 60; k++) begin
            int          op;
            logic [5:0]  w;
            logic [31:0] base;
            op = $urandom_range(0, 3);
            c1_rd_data = {$urandom, $urandom, $urandom, $urandom};
            c2_rd_data = {$urandom, $urandom};
            fc_rd_data = $urandom;
            base = ($urandom_range(0, 9) == 0) ? 32'h3000_0100 : 32'h3000_0000;
            case (op)
                0: begin
                    w = 6'($urandom_range(4, 7));
                    step("rnd_wd", base | {24'd0, w, 2'b00}, $urandom, 4'($urandom), 1'b1);
                end
                1: step("rnd_cmd", base, $urandom,
                        ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF, 1'b1);
                2: begin
                    w = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 11));
                    step("rnd_rd", base | {24'd0, w, 2'b00}, 32'h0, 4'hF, 1'b0);
                end
                default: begin
                    w = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(1, 3)) : 6'($urandom_range(8, 63));
                    step("rnd_ign", base | {24'd0, w, 2'b00}, $urandom, 4'hF, 1'b1);
                end
            endcase
        end

        // Reset landing in the strobe cycle of a conv2 read.
        c2_rd_data = 64'h0123_4567_89AB_CDEF;
        bus.wbs_adr_i = 32'h3000_0000; bus.wbs_dat_i = 32'h0005_0101; bus.wbs_sel_i = 4'hF;
        bus.wbs_we_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        chk("rstmid/pre", {bus.wbs_ack_o, w_strobes}, {1'b1, (RB ? 6'b010000 : 6'b000000)});
        rst = 1'b1;
        #1;
        chk("rstmid/drop", {bus.wbs_ack_o, w_strobes}, '0);
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        @(posedge clk); #1;
        check_outputs("rstmid");
        step("rstmid_rd0", 32'h3000_0020, 32'h0, 4'hF, 1'b0);
        step("rstmid_rd1", 32'h3000_0024, 32'h0, 4'hF, 1'b0);
        step("rstmid_st",  32'h3000_0004, 32'h0, 4'hF, 1'b0);
        step("rstmid_cmd", 32'h3000_0000, 32'h0, 4'hF, 1'b0);

        chk("one_hot_strobes", n_multi, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
